// File: rtl/irq_sequencer_if.sv
// Interrupt sequencer bus: interrupt sources, enables and the trap handshake.
// slave  : the sequencer (sources/enables/ack/mret in; req/cause/mip/status out)
// master : the core/CSR side (drives sources, enables, ack and mret)
interface irq_sequencer_if #(
   parameter int unsigned XLEN = 64
);
   logic            msip;
   logic            mtip;
   logic            meip;
   logic            mstatus_mie;
   logic [XLEN-1:0] mie;
   logic            irq_ack;
   logic            mret;
   logic            irq_req;
   logic [XLEN-1:0] irq_cause;
   logic [XLEN-1:0] mip;
   logic            in_trap;
   logic [XLEN-1:0] irq_count;

   modport slave (
      input  msip, mtip, meip, mstatus_mie, mie, irq_ack, mret,
      output irq_req, irq_cause, mip, in_trap, irq_count
   );

   modport master (
      output msip, mtip, meip, mstatus_mie, mie, irq_ack, mret,
      input  irq_req, irq_cause, mip, in_trap, irq_count
   );
endinterface

// File: rtl/irq_sequencer.sv
// Machine-mode interrupt sequencer: picks the highest-priority enabled
// pending interrupt, presents it as a trap request held until ack, then
// blocks further requests until MRET.
// Ports:
//   clk  - core clock
//   rst  - asynchronous reset, active-low
//   bus  - irq_sequencer_if.slave (sources, enables, ack/mret in;
//          irq_req, irq_cause, mip, in_trap, irq_count out)
// Optional feature: define IRQ_SEQ_STATS_EN to build the taken-interrupt
// counter on irq_count; otherwise irq_count is tied to zero.
module irq_sequencer #(
   parameter int unsigned XLEN        = 64,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic           clk,
   input logic           rst,
   irq_sequencer_if.slave bus
);
   localparam int unsigned CODE_W   = 4;
   localparam logic [CODE_W-1:0] CODE_MSI = 4'd3;
   localparam logic [CODE_W-1:0] CODE_MTI = 4'd7;
   localparam logic [CODE_W-1:0] CODE_MEI = 4'd11;

   typedef enum logic [1:0] {IDLE, REQ, TRAP} state_e;

   state_e              state_q, state_d;
   logic                req_q, req_d;
   logic                trap_q, trap_d;
   logic [XLEN-1:0]     cause_q, cause_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [SYNC_STAGES-1:0] meip_sync_q;
   logic                meip_s;
   logic [XLEN-1:0]     mip_c;
   logic                pend_msi, pend_mti, pend_mei;
   logic                eligible;
   logic                held;
   logic [CODE_W-1:0]   win_code;
   logic                unused_mie;

   // meip is asynchronous: pass it through the synchronizer chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) meip_sync_q <= '0;
      else      meip_sync_q <= {meip_sync_q[SYNC_STAGES-2:0], bus.meip};
   end
   assign meip_s = meip_sync_q[SYNC_STAGES-1];

   // Pending view; forced to zero while reset is asserted
   always_comb begin
      mip_c     = '0;
      mip_c[3]  = bus.msip;
      mip_c[7]  = bus.mtip;
      mip_c[11] = meip_s;
      if (!rst) mip_c = '0;
   end

   assign pend_msi   = mip_c[3]  & bus.mie[3];
   assign pend_mti   = mip_c[7]  & bus.mie[7];
   assign pend_mei   = mip_c[11] & bus.mie[11];
   assign eligible   = bus.mstatus_mie & (pend_msi | pend_mti | pend_mei);
   assign unused_mie = ^bus.mie;

   // Fixed priority MEI > MSI > MTI
   always_comb begin
      win_code = CODE_MTI;
      if (pend_mei)      win_code = CODE_MEI;
      else if (pend_msi) win_code = CODE_MSI;
   end

   // Is the latched source still pending and enabled?
   always_comb begin
      held = 1'b0;
      case (code_q)
         CODE_MSI: held = pend_msi;
         CODE_MTI: held = pend_mti;
         CODE_MEI: held = pend_mei;
         default:  held = 1'b0;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         trap_q  <= 1'b0;
         cause_q <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
         code_q  <= code_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      trap_d  = trap_q;
      cause_d = cause_q;
      code_d  = code_q;
      case (state_q)
         IDLE: begin
            if (eligible) begin
               state_d             = REQ;
               req_d               = 1'b1;
               code_d              = win_code;
               cause_d             = '0;
               cause_d[XLEN-1]     = 1'b1;
               cause_d[CODE_W-1:0] = win_code;
            end
         end
         REQ: begin
            // ack wins over a simultaneous withdraw
            if (bus.irq_ack) begin
               state_d = TRAP;
               req_d   = 1'b0;
               trap_d  = 1'b1;
            end else if (!held || !bus.mstatus_mie) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         TRAP: begin
            if (bus.mret) begin
               state_d = IDLE;
               trap_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            trap_d  = 1'b0;
         end
      endcase
   end

   assign bus.irq_req   = req_q;
   assign bus.irq_cause = cause_q;
   assign bus.in_trap   = trap_q;
   assign bus.mip       = mip_c;

`ifdef IRQ_SEQ_STATS_EN
   logic            take_c;
   logic [XLEN-1:0] count_q;

   assign take_c = (state_q == REQ) & bus.irq_ack;

   // Taken-interrupt counter, wraps naturally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        count_q <= '0;
      else if (take_c) count_q <= count_q + XLEN'(1);
   end
   assign bus.irq_count = count_q;
`else
   assign bus.irq_count = '0;
`endif
endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Machine-mode interrupt sequencer between the core-local timer/software interrupt unit, the external interrupt line and the core's trap-entry logic.
- Combines pending sources with the enable state, picks one by fixed RISC-V priority, and raises a single trap request with its cause.
- Holds that request stable until the core acknowledges it, then blocks further requests until the trap returns.
- Also drives the mip view for the CSR file.

Parameters:
- XLEN, 64, data width of the mie, mip and cause words and of the statistics counter.
- SYNC_STAGES, 2, number of synchronizer flops on meip; legal range 2..3.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- msip  in  1  software interrupt pending; already registered in the clk domain
- mtip  in  1  timer interrupt pending; already registered in the clk domain
- meip  in  1  external interrupt pending; asynchronous, level
- mstatus_mie  in  1  global machine interrupt enable
- mie  in  XLEN  interrupt enable CSR; bits 3 (MSIE), 7 (MTIE), 11 (MEIE) used
- irq_ack  in  1  core has entered the trap for the presented cause
- mret  in  1  core executed MRET (one-cycle pulse)
- irq_req  out  1  trap request to core
- irq_cause  out  XLEN  mcause value for the request
- mip  out  XLEN  pending view: bit3=msip, bit7=mtip, bit11=synced meip, others 0
- in_trap  out  1  an acknowledged interrupt trap is in progress
- irq_count  out  XLEN  taken-interrupt count (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, irq_req=0, irq_cause=0, in_trap=0, mip=0, irq_count=0.
  - Synchronizer flops cleared.
- meip passes through SYNC_STAGES flops before use. mip is driven combinationally from msip, mtip and the synced meip.
- Request eligibility: pend = mip & mie. A request is eligible when mstatus_mie=1 and pend[11|7|3]!=0.
- Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- Cause encoding: irq_cause = {1'b1, (XLEN-5)'b0, code[3:0]}, i.e. bit XLEN-1 set.
- FSM states IDLE, REQ, TRAP:
  - IDLE:
    - If eligible at cycle N: latch winning cause and go to REQ. irq_req=1 and irq_cause are valid from cycle N+1 (one-cycle latency).
    - mret in IDLE is ignored.
  - REQ:
    - irq_req=1; irq_cause is held constant, and a higher-priority source arriving later does not replace it.
    - irq_ack=1: go to TRAP; irq_req=0 next cycle; in_trap=1 next cycle.
    - Else if the latched source is no longer in pend, or mstatus_mie=0: withdraw. Go to IDLE, irq_req=0 next cycle, irq_cause keeps its last value. Re-evaluation happens from IDLE on the following cycle.
    - irq_ack and withdraw conditions in the same cycle: ack wins.
  - TRAP:
    - irq_req stays 0 regardless of pend.
    - mret=1: go to IDLE and in_trap=0 next cycle. The earliest new irq_req is 2 cycles after the mret cycle.
- irq_ack outside REQ is ignored (no state change, no count).
- Asserting reset in any state forces IDLE immediately. An unacknowledged request is dropped; no count increment.

Optional Feature:
- Macro IRQ_SEQ_STATS_EN.
- Defined:
  - irq_count increments by 1 on every accepted irq_ack (state REQ and irq_ack=1).
  - Wraps from all-ones to 0.
  - Cleared only by reset.
- Undefined:
  - irq_count is tied to 0 and no counter flops are built.
  - Port list is unchanged.

Test Plan:
- Reset release, mstatus_mie=1, mie=0x80, mtip rises at cycle 10:
  - irq_req=1 at cycle 11 with irq_cause=0x8000000000000007.
  - irq_ack at cycle 14 -> irq_req=0 and in_trap=1 at cycle 15.
  - mret at cycle 20 -> in_trap=0 at cycle 21.
- mie=0x888; msip and mtip both set while idle, and meip asserted the same cycle:
  - First cause=code 3 (MSI), since meip is still in the synchronizer.
  - Request held at code 3 while meip syncs.
  - After ack and mret, the next request has cause code 11.
- Request pending on mtip, no ack; mtip drops (mtimecmp rewrite):
  - irq_req=0 next cycle and state returns to IDLE.
  - With irq_ack and the mtip drop in the same cycle -> trap accepted and in_trap=1.
- mstatus_mie=0 with msip=1, mie=0x8:
  - irq_req never rises.
  - Setting mstatus_mie=1 -> irq_req=1 one cycle later, cause code 3.
- rst asserted while in REQ:
  - All outputs 0 immediately (asynchronously).
  - After release with sources still pending -> irq_req again 1 cycle after the first clk edge with rst high.
- With IRQ_SEQ_STATS_EN, three ack/mret rounds -> irq_count=3; spurious irq_ack in IDLE leaves it at 3. Without the macro, irq_count stays 0 throughout.
